// File: rtl/mult_seq_n_if.sv
// mult_seq_n_if
// Handshake and data bus of the sequential multiplier.
//   master : drives Start, Load_B, Signed_Mode and the operand bus S
//   slave  : the multiplier; returns Busy, Done, X, A, B and Product
// WIDTH is the operand width and must match the multiplier instance.
interface mult_seq_n_if #(
  parameter int WIDTH = 8
);
  logic                   Start;
  logic                   Load_B;
  logic                   Signed_Mode;
  logic [WIDTH-1:0]       S;
  logic                   Busy;
  logic                   Done;
  logic                   X;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic [2*WIDTH-1:0]     Product;

  modport master (
    output Start, Load_B, Signed_Mode, S,
    input  Busy, Done, X, A, B, Product
  );

  modport slave (
    input  Start, Load_B, Signed_Mode, S,
    output Busy, Done, X, A, B, Product
  );
endinterface

// File: rtl/mult_seq_n.sv
// mult_seq_n
// Sequential add-shift multiplier for two WIDTH-bit operands, signed or
// unsigned. The multiplier is loaded into B with Load_B, the multiplicand
// is captured from S on Start. The 2*WIDTH-bit product ends up in {A, B},
// with X as the extension bit above A.
// Ports:
//   Clk    : system clock, rising edge
//   Reset  : synchronous, active-high
//   bus    : mult_seq_n_if slave modport
//            in : Start, Load_B, Signed_Mode, S
//            out: Busy (ADD/SHIFT), Done (DONE), X, A, B, Product = {A, B}
module mult_seq_n #(
  parameter int WIDTH = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  mult_seq_n_if.slave   bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               x_reg;
  logic [WIDTH-1:0]   mreg;
  logic               sgn;
  logic [CW-1:0]      cnt;
  logic               busy_reg;
  logic               done_reg;

  logic [WIDTH:0]     ext_a;
  logic [WIDTH:0]     ext_m;
  logic               subtract;
  logic [WIDTH:0]     sum;

  // Accumulator update for one ADD step. In signed mode the multiplier's
  // top bit has negative weight, so the last step subtracts the
  // multiplicand (add of the complement with carry-in 1). The WIDTH+1
  // extension keeps most-negative x most-negative exact.
  always_comb begin
    ext_a    = sgn ? {a_reg[WIDTH-1], a_reg} : {1'b0, a_reg};
    ext_m    = sgn ? {mreg[WIDTH-1], mreg}   : {1'b0, mreg};
    subtract = sgn && (cnt == LAST);
    sum      = ext_a + (subtract ? ~ext_m : ext_m) + {{WIDTH{1'b0}}, subtract};
  end

  // Control FSM and datapath registers. Busy and Done are registered
  // alongside the state so they track it exactly.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      x_reg    <= 1'b0;
      mreg     <= '0;
      sgn      <= 1'b0;
      cnt      <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Load_B) begin
            b_reg <= bus.S;
            a_reg <= '0;
            x_reg <= 1'b0;
          end else if (bus.Start) begin
            mreg     <= bus.S;
            sgn      <= bus.Signed_Mode;
            a_reg    <= '0;
            x_reg    <= 1'b0;
            cnt      <= '0;
            busy_reg <= 1'b1;
            state    <= ADD;
          end
        end
        ADD: begin
          if (b_reg[0]) begin
            {x_reg, a_reg} <= sum;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          // Arithmetic shift in signed mode; in unsigned mode X is the carry
          // of the last add and drops into A while a zero refills X.
          {x_reg, a_reg, b_reg} <= {sgn & x_reg, x_reg, a_reg, b_reg[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            state    <= DONE;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          // Start must be seen low before another run can begin.
          if (bus.Load_B) begin
            b_reg <= bus.S;
            a_reg <= '0;
            x_reg <= 1'b0;
          end else if (!bus.Start) begin
            done_reg <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy    = busy_reg;
  assign bus.Done    = done_reg;
  assign bus.X       = x_reg;
  assign bus.A       = a_reg;
  assign bus.B       = b_reg;
  assign bus.Product = {a_reg, b_reg};

endmodule

// File: tb/tb_mult_seq_n.sv
// tb_mult_seq_n
// Self-checking bench for mult_seq_n: a WIDTH=8 instance driven by a table
// of hand-computed vectors, handshake/abort/reset sequences and a random
// sweep against a reference multiply, plus a WIDTH=16 instance.
module tb_mult_seq_n;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  mult_seq_n_if #(.WIDTH(8))  bus8 ();
  mult_seq_n_if #(.WIDTH(16)) bus16 ();

  mult_seq_n #(.WIDTH(8)) dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus8.slave)
  );

  mult_seq_n #(.WIDTH(16)) dut16 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus16.slave)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sgn;
    logic [7:0] b_init;
    logic [7:0] mcand;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_x;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Load B, start with the multiplicand, wait for Done (bounded), then drop
  // Start so the DUT returns to IDLE. Product is held afterwards.
  task automatic applyStimulus(input logic sgn, input logic [7:0] b_init,
                               input logic [7:0] mcand, output int busy_cycles,
                               output bit done_seen);
    int n;
    @(negedge Clk);
    bus8.Load_B = 1'b1;
    bus8.S      = b_init;
    bus8.Start  = 1'b0;
    @(negedge Clk);
    bus8.Load_B      = 1'b0;
    bus8.Start       = 1'b1;
    bus8.S           = mcand;
    bus8.Signed_Mode = sgn;
    @(negedge Clk);
    bus8.Start = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (!bus8.Done && n < 100) begin
      if (bus8.Busy) busy_cycles++;
      n++;
      @(negedge Clk);
    end
    done_seen = bus8.Done;
    @(negedge Clk);
  endtask

  task automatic run16(input logic sgn, input logic [15:0] b_init,
                       input logic [15:0] mcand, output int busy_cycles,
                       output bit done_seen);
    int n;
    @(negedge Clk);
    bus16.Load_B = 1'b1;
    bus16.S      = b_init;
    @(negedge Clk);
    bus16.Load_B      = 1'b0;
    bus16.Start       = 1'b1;
    bus16.S           = mcand;
    bus16.Signed_Mode = sgn;
    @(negedge Clk);
    bus16.Start = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (!bus16.Done && n < 100) begin
      if (bus16.Busy) busy_cycles++;
      n++;
      @(negedge Clk);
    end
    done_seen = bus16.Done;
    @(negedge Clk);
  endtask

  initial begin
    int         bc;
    bit         ds;
    bit         stable;
    int         n;
    logic [7:0] rb;
    logic [7:0] rm;
    logic       rs;
    logic signed [15:0] sp;
    logic [15:0] up;

    vecs[0] = '{1'b1, 8'h07, 8'hFD, 8'hFF, 8'hEB, 1'b1};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0};
    vecs[4] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0};
    vecs[5] = '{1'b0, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 8'h7F, 8'h80, 8'hC0, 8'h80, 1'b1};
    vecs[7] = '{1'b0, 8'h0D, 8'h0B, 8'h00, 8'h8F, 1'b0};
    vecs[8] = '{1'b1, 8'h01, 8'h80, 8'hFF, 8'h80, 1'b1};
    vecs[9] = '{1'b1, 8'h80, 8'h01, 8'hFF, 8'h80, 1'b1};

    bus8.Start = 1'b0;  bus8.Load_B = 1'b0;  bus8.Signed_Mode = 1'b0;  bus8.S = '0;
    bus16.Start = 1'b0; bus16.Load_B = 1'b0; bus16.Signed_Mode = 1'b0; bus16.S = '0;

    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("reset_busy", 64'(bus8.Busy), 64'd0);
    checkOutput("reset_done", 64'(bus8.Done), 64'd0);
    checkOutput("reset_x", 64'(bus8.X), 64'd0);
    checkOutput("reset_prod8", 64'(bus8.Product), 64'd0);
    checkOutput("reset_prod16", 64'(bus16.Product), 64'd0);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].b_init, vecs[i].mcand, bc, ds);
      checkOutput($sformatf("vec%0d_done", i), 64'(ds), 64'd1);
      checkOutput($sformatf("vec%0d_busy", i), 64'(bc), 64'd16);
      checkOutput($sformatf("vec%0d_a", i), 64'(bus8.A), 64'(vecs[i].exp_a));
      checkOutput($sformatf("vec%0d_b", i), 64'(bus8.B), 64'(vecs[i].exp_b));
      checkOutput($sformatf("vec%0d_x", i), 64'(bus8.X), 64'(vecs[i].exp_x));
    end

    // Start held through DONE: no retrigger, then a second run reusing B
    @(negedge Clk);
    bus8.Load_B = 1'b1; bus8.S = 8'h07;
    @(negedge Clk);
    bus8.Load_B = 1'b0; bus8.Start = 1'b1; bus8.S = 8'hFD; bus8.Signed_Mode = 1'b1;
    n = 0;
    @(negedge Clk);
    while (!bus8.Done && n < 100) begin n++; @(negedge Clk); end
    checkOutput("hold_done", 64'(bus8.Done), 64'd1);
    stable = 1'b1;
    repeat (10) begin
      @(negedge Clk);
      if (!bus8.Done || bus8.Busy || bus8.Product !== 16'hFFEB) stable = 1'b0;
    end
    checkOutput("hold_stable", 64'(stable), 64'd1);
    bus8.Start = 1'b0;
    @(negedge Clk);
    checkOutput("drop_start_idle", 64'(bus8.Done), 64'd0);
    bus8.Start = 1'b1; bus8.S = 8'h02; bus8.Signed_Mode = 1'b1;
    @(negedge Clk);
    bus8.Start = 1'b0;
    n = 0;
    while (!bus8.Done && n < 100) begin n++; @(negedge Clk); end
    checkOutput("rerun_done", 64'(bus8.Done), 64'd1);
    checkOutput("rerun_prod", 64'(bus8.Product), 64'hFFD6);
    checkOutput("rerun_x", 64'(bus8.X), 64'd1);
    @(negedge Clk);

    // Inputs toggled mid-run must not disturb the result
    @(negedge Clk);
    bus8.Load_B = 1'b1; bus8.S = 8'h0D;
    @(negedge Clk);
    bus8.Load_B = 1'b0; bus8.Start = 1'b1; bus8.S = 8'h0B; bus8.Signed_Mode = 1'b0;
    @(negedge Clk);
    bus8.Start = 1'b0;
    repeat (3) @(negedge Clk);
    bus8.S = 8'hFF; bus8.Signed_Mode = 1'b1; bus8.Load_B = 1'b1;
    repeat (2) @(negedge Clk);
    bus8.Load_B = 1'b0; bus8.S = 8'h33;
    n = 0;
    while (!bus8.Done && n < 100) begin n++; @(negedge Clk); end
    checkOutput("toggle_done", 64'(bus8.Done), 64'd1);
    checkOutput("toggle_prod", 64'(bus8.Product), 64'h008F);
    checkOutput("toggle_x", 64'(bus8.X), 64'd0);
    @(negedge Clk);

    // Reset during Busy
    @(negedge Clk);
    bus8.Load_B = 1'b1; bus8.S = 8'h07;
    @(negedge Clk);
    bus8.Load_B = 1'b0; bus8.Start = 1'b1; bus8.S = 8'hFD; bus8.Signed_Mode = 1'b1;
    @(negedge Clk);
    bus8.Start = 1'b0;
    repeat (4) @(negedge Clk);
    checkOutput("abort_busy_before", 64'(bus8.Busy), 64'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checkOutput("abort_busy", 64'(bus8.Busy), 64'd0);
    checkOutput("abort_done", 64'(bus8.Done), 64'd0);
    checkOutput("abort_prod", 64'(bus8.Product), 64'd0);
    checkOutput("abort_x", 64'(bus8.X), 64'd0);
    applyStimulus(1'b0, 8'h05, 8'h06, bc, ds);
    checkOutput("post_abort_done", 64'(ds), 64'd1);
    checkOutput("post_abort_prod", 64'(bus8.Product), 64'h001E);

    // WIDTH=16 instance
    run16(1'b1, 16'h8000, 16'h7FFF, bc, ds);
    checkOutput("w16_done", 64'(ds), 64'd1);
    checkOutput("w16_busy", 64'(bc), 64'd32);
    checkOutput("w16_prod", 64'(bus16.Product), 64'hC0008000);
    checkOutput("w16_x", 64'(bus16.X), 64'd1);
    run16(1'b0, 16'hFFFF, 16'hFFFF, bc, ds);
    checkOutput("w16u_prod", 64'(bus16.Product), 64'hFFFE0001);
    checkOutput("w16u_x", 64'(bus16.X), 64'd0);

    // Random sweep of both modes against a reference multiply
    for (int i = 0; i < 1000; i++) begin
      rb = 8'($urandom);
      rm = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      applyStimulus(rs, rb, rm, bc, ds);
      if (rs) begin
        sp = $signed(rb) * $signed(rm);
        up = sp;
      end else begin
        up = {8'h00, rb} * {8'h00, rm};
      end
      checkOutput($sformatf("rand%0d_prod", i), 64'(bus8.Product), 64'(up));
      checkOutput($sformatf("rand%0d_x", i), 64'(bus8.X), 64'(rs & up[15]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
